// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one 8-bit ALU; per-op hold latency, one op in flight.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned ADD_LAT   = 2,
  parameter int unsigned LOGIC_LAT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data1,
  input  logic [7:0] req0_data2,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data1,
  input  logic [7:0] req1_data2,
  input  logic [2:0] req1_op,
  output logic       resp0_valid,
  input  logic       resp0_ready,
  output logic [7:0] resp0_result,
  output logic       resp0_err,
  output logic       resp1_valid,
  input  logic       resp1_ready,
  output logic [7:0] resp1_result,
  output logic       resp1_err,
  output logic [7:0] alu_data1,
  output logic [7:0] alu_data2,
  output logic [2:0] alu_operation,
  input  logic [7:0] alu_result
);

  // state | meaning
  // IDLE  | waiting for a request; ready offered to the selected requester
  // EXEC  | latched operands on the ALU, latency counter running
  // RESP  | result held for the granted requester until it is consumed
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt_q;
  logic [7:0] d1_q, d2_q, res_q;
  logic [2:0] op_q;
  logic       gid_q, err_q;

  logic       contend_win, sel, xfer, done, resp_rdy;
  logic [7:0] in_d1, in_d2;
  logic [2:0] in_op, lat_ld;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  // Pointer only moves when a response is consumed, so aborted ops never shift fairness.
  logic last_q;
  always_ff @(posedge CLK) begin
    if (RESET)
      last_q <= 1'b1;
    else if (state == RESP && resp_rdy)
      last_q <= gid_q;
  end
  assign contend_win = ~last_q;
`else
  assign contend_win = 1'b0;
`endif

  assign sel      = (req0_valid && req1_valid) ? contend_win : req1_valid;
  assign xfer     = !RESET && state == IDLE && (sel ? req1_valid : req0_valid);
  assign in_d1    = sel ? req1_data1 : req0_data1;
  assign in_d2    = sel ? req1_data2 : req0_data2;
  assign in_op    = sel ? req1_op    : req0_op;
  assign done     = state == EXEC && cnt_q == 3'd1;
  assign resp_rdy = gid_q ? resp1_ready : resp0_ready;

  always_comb begin
    lat_ld = 3'd1;
    case (in_op)
      3'b001:                 lat_ld = 3'(ADD_LAT);
      3'b000, 3'b010, 3'b011: lat_ld = 3'(LOGIC_LAT);
      default:                lat_ld = 3'd1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer)     state_nxt = EXEC;
      EXEC:    if (done)     state_nxt = RESP;
      RESP:    if (resp_rdy) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // The latched operands drive the ALU directly, so its inputs only change on acceptance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= 3'd0;
      d1_q  <= 8'h00;
      d2_q  <= 8'h00;
      op_q  <= 3'd0;
      gid_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= 8'h00;
    end else begin
      if (xfer) begin
        cnt_q <= lat_ld;
        d1_q  <= in_d1;
        d2_q  <= in_d2;
        op_q  <= in_op;
        gid_q <= sel;
        err_q <= in_op[2];
      end else if (state == EXEC) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if (done)
        res_q <= err_q ? 8'h00 : alu_result;
    end
  end

  always_comb begin
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    resp0_valid   = 1'b0;
    resp1_valid   = 1'b0;
    resp0_result  = 8'h00;
    resp1_result  = 8'h00;
    resp0_err     = 1'b0;
    resp1_err     = 1'b0;
    alu_data1     = d1_q;
    alu_data2     = d2_q;
    alu_operation = op_q;
    if (!RESET) begin
      if (state == IDLE) begin
        req0_ready = req0_valid && !sel;
        req1_ready = req1_valid && sel;
      end
      if (state == RESP) begin
        if (gid_q) begin
          resp1_valid  = 1'b1;
          resp1_result = res_q;
          resp1_err    = err_q;
        end else begin
          resp0_valid  = 1'b1;
          resp0_result = res_q;
          resp0_err    = err_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + randomized transactions against a transaction-level model.
// Build with or without ALU_ARB_ROUND_ROBIN_EN; the model follows the same macro.
module tb_alu_arbiter;

  localparam int ADD_LAT   = 2;
  localparam int LOGIC_LAT = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic [2:0] req0_op, req1_op;
  logic       resp0_valid, resp0_ready, resp0_err;
  logic       resp1_valid, resp1_ready, resp1_err;
  logic [7:0] resp0_result, resp1_result;
  logic [7:0] alu_data1, alu_data2, alu_result;
  logic [2:0] alu_operation;

  int n_checks = 0;
  int n_fail   = 0;
  bit last     = 1'b1;

  always #5 clk = ~clk;

  // Shared ALU stub; illegal codes return a nonzero pattern so error masking is observable.
  always_comb begin
    case (alu_operation)
      3'b000:  alu_result = alu_data1;
      3'b001:  alu_result = alu_data1 + alu_data2;
      3'b010:  alu_result = alu_data1 & alu_data2;
      3'b011:  alu_result = alu_data1 | alu_data2;
      default: alu_result = 8'hA5;
    endcase
  end

  alu_arbiter #(.ADD_LAT(ADD_LAT), .LOGIC_LAT(LOGIC_LAT)) dut (
    .CLK(clk), .RESET(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
    .req0_data2(req0_data2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
    .req1_data2(req1_data2), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_err(resp1_err),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_operation(alu_operation),
    .alu_result(alu_result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    if (op == 3'b001) return ADD_LAT;
    if (op[2]) return 1;
    return LOGIC_LAT;
  endfunction

  function automatic bit pick(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      return ~last;
`else
      return 1'b0;
`endif
    end
    return v1;
  endfunction

  task automatic all_outputs_zero(input string tag);
    check({tag, "_outs"},
          {31'd0, |{req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err,
                    resp0_result, resp1_result, alu_data1, alu_data2, alu_operation}}, 32'd0);
  endtask

  task automatic txn(input bit v0, input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                     input bit v1, input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                     input int rdelay);
    bit w;
    bit got;
    int n;
    logic [2:0] op;
    logic [7:0] a, b, er;
    w  = pick(v0, v1);
    op = w ? op1 : op0;
    a  = w ? a1 : a0;
    b  = w ? b1 : b0;
    er = exp_result(op, a, b);
    @(negedge clk);
    req0_valid = v0; req0_op = op0; req0_data1 = a0; req0_data2 = b0;
    req1_valid = v1; req1_op = op1; req1_data1 = a1; req1_data2 = b1;
    #1;
    check("ready0", {31'd0, req0_ready}, {31'd0, v0 && !w});
    check("ready1", {31'd0, req1_ready}, {31'd0, v1 && w});
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("alu_d1", {24'd0, alu_data1}, {24'd0, a});
        check("alu_d2", {24'd0, alu_data2}, {24'd0, b});
        check("alu_op", {29'd0, alu_operation}, {29'd0, op});
      end
      got = w ? resp1_valid : resp0_valid;
    end
    check("latency", n, exp_lat(op) + 1);
    if (got) begin
      check("result", {24'd0, w ? resp1_result : resp0_result}, {24'd0, er});
      check("err", {31'd0, w ? resp1_err : resp0_err}, {31'd0, op[2]});
      check("other_valid", {31'd0, w ? resp0_valid : resp1_valid}, 32'd0);
      for (int i = 0; i < rdelay; i++) begin
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        check("stall_valid", {31'd0, w ? resp1_valid : resp0_valid}, 32'd1);
        check("stall_result", {24'd0, w ? resp1_result : resp0_result}, {24'd0, er});
        check("stall_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (w) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(negedge clk);
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
      check("resp_done", {30'd0, resp1_valid, resp0_valid}, 32'd0);
      last = w;
    end
  endtask

  initial begin
    bit resp_seen;
    rst = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_data1 = 8'h00; req0_data2 = 8'h00;
    req1_valid = 1'b1; req1_op = 3'd0; req1_data1 = 8'h00; req1_data2 = 8'h00;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    repeat (3) @(negedge clk);
    all_outputs_zero("reset");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    txn(1, 3'b001, 8'h05, 8'h03, 0, 3'b000, 8'h00, 8'h00, 0);
    txn(0, 3'b000, 8'h00, 8'h00, 1, 3'b011, 8'hF0, 8'h0F, 0);
    txn(1, 3'b110, 8'h12, 8'h34, 0, 3'b000, 8'h00, 8'h00, 0);
    txn(1, 3'b000, 8'h5A, 8'h00, 0, 3'b000, 8'h00, 8'h00, 0);
    txn(1, 3'b010, 8'h3C, 8'h0F, 0, 3'b000, 8'h00, 8'h00, 4);
    for (int i = 0; i < 4; i++)
      txn(1, 3'b010, 8'hF3, 8'h3F, 1, 3'b010, 8'hAA, 8'h0F, 0);

    // Abort an ADD mid-execution; nothing may ever be delivered for it.
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 3'b001; req0_data1 = 8'h11; req0_data2 = 8'h22;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    all_outputs_zero("mid_exec_reset");
    rst = 1'b0;
    resp_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      resp_seen |= resp0_valid | resp1_valid;
    end
    check("abandoned_resp", {31'd0, resp_seen}, 32'd0);
    last = 1'b1;
    txn(1, 3'b011, 8'h01, 8'h02, 1, 3'b011, 8'h04, 8'h08, 0);

    for (int i = 0; i < 60; i++) begin
      bit v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      txn(v0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
          v1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
          int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
